// File: rtl/gpu_bus_arb.sv
// -----------------------------------------------------------------------------
// gpu_bus_arb
//
// Main-memory bus arbiter. It shares the external bus between NREQ masters
// (object processor/refresh, GPU, blitter, CPU, ...).
//
// Priority scheme:
//   - Index 0 has fixed top priority.
//   - The GPU (HOG_IDX) wins next while its bus_hog bit is set.
//   - The remaining masters (1..NREQ-1) are served round-robin.
//
// Ownership changes only on transfer boundaries, and every handover passes
// through a one-cycle turnaround (TURN) followed by the arbitration cycle (IDLE).
//
// Parameters:
//   NREQ      number of requesters (2..8)
//   HOG_IDX   requester index affected by bus_hog (the GPU)
//   MAX_BURST transfers an owner may take under contention before forced release
//
// Ports:
//   sys_clk   in   system clock, rising-edge active
//   reset     in   asynchronous, active-high reset
//   req       in   per-requester request levels [NREQ]
//   xfer_done in   one-cycle pulse: current owner's transfer completed
//   bus_hog   in   GPU bus-hog enable (GPU control register bit 11)
//   gnt       out  registered one-hot grant, zero when no owner [NREQ]
//   gnt_id    out  index of current owner, holds last owner when gnt is zero [3]
//   bus_idle  out  high while no grant is active (IDLE and TURN)
//   burst_cnt out  transfers completed by the current owner since grant [8]
// -----------------------------------------------------------------------------
module gpu_bus_arb #(
    parameter int NREQ      = 4,
    parameter int HOG_IDX   = 1,
    parameter int MAX_BURST = 8
) (
    input  logic            sys_clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            xfer_done,
    input  logic            bus_hog,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      gnt_id,
    output logic            bus_idle,
    output logic [7:0]      burst_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    // Registered state and outputs
    state_t          r_state;
    logic [NREQ-1:0] r_gnt;
    logic [2:0]      r_gnt_id;
    logic            r_bus_idle;
    logic [7:0]      r_burst_cnt;
    logic [2:0]      r_rr;

    // Next-state values
    state_t          w_state_nxt;
    logic [NREQ-1:0] w_gnt_nxt;
    logic [2:0]      w_gnt_id_nxt;
    logic            w_bus_idle_nxt;
    logic [7:0]      w_burst_cnt_nxt;
    logic [2:0]      w_rr_nxt;

    // Arbitration results
    logic            w_hi_found;
    logic [2:0]      w_hi_id;
    logic [2:0]      w_lo_id;
    logic [2:0]      w_win_id;
    logic [NREQ-1:0] w_win_oh;

    // Release conditions
    logic            w_owner_req;
    logic            w_other_req;
    logic            w_at_limit;
    logic            w_hog_exempt;
    logic            w_release;
    logic [7:0]      w_burst_inc;

    // One-hot encode a requester index
    function automatic logic [NREQ-1:0] f_onehot(input logic [2:0] id);
        logic [NREQ-1:0] v;
        for (int i = 0; i < NREQ; i++) begin
            v[i] = (id == 3'(i));
        end
        return v;
    endfunction

    // Winner selection.
    // The round-robin search covers 1..NREQ-1, starting just above r_rr. It is
    // done as two descending scans, so the lowest matching index wins each scan:
    //   - the "hi" scan looks only above r_rr;
    //   - the "lo" scan covers the whole range and supplies the wrap-around
    //     candidate.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_id    = 3'd0;
        w_lo_id    = 3'd0;
        for (int i = NREQ - 1; i >= 1; i--) begin
            w_hi_found = (req[i] && (3'(i) > r_rr)) ? 1'b1  : w_hi_found;
            w_hi_id    = (req[i] && (3'(i) > r_rr)) ? 3'(i) : w_hi_id;
            w_lo_id    = req[i] ? 3'(i) : w_lo_id;
        end
        if (req[0]) begin
            w_win_id = 3'd0;
        end else if (bus_hog && req[HOG_IDX]) begin
            w_win_id = 3'(HOG_IDX);
        end else if (w_hi_found) begin
            w_win_id = w_hi_id;
        end else begin
            w_win_id = w_lo_id;
        end
        w_win_oh = f_onehot(w_win_id);
    end

    // r_gnt is the owner's one-hot in OWN, so it splits req into owner and others
    assign w_owner_req  = |(req & r_gnt);
    assign w_other_req  = |(req & ~r_gnt);
    assign w_at_limit   = (({1'b0, r_burst_cnt} + 9'd1) >= 9'(MAX_BURST));
    // A pending top-priority request cancels the GPU's hog exemption
    assign w_hog_exempt = r_gnt[HOG_IDX] & bus_hog & ~req[0];
    assign w_release    = ~w_owner_req
                        | (xfer_done & w_at_limit & w_other_req & ~w_hog_exempt);
    assign w_burst_inc  = (r_burst_cnt == 8'd255) ? 8'd255 : (r_burst_cnt + 8'd1);

    // Next-state and next-output logic for the IDLE/OWN/TURN controller
    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_gnt_id_nxt    = r_gnt_id;
        w_bus_idle_nxt  = r_bus_idle;
        w_burst_cnt_nxt = r_burst_cnt;
        w_rr_nxt        = r_rr;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_nxt     = ST_OWN;
                    w_gnt_nxt       = w_win_oh;
                    w_gnt_id_nxt    = w_win_id;
                    w_burst_cnt_nxt = 8'd0;
                    w_bus_idle_nxt  = 1'b0;
                end else begin
                    w_state_nxt     = ST_IDLE;
                    w_gnt_nxt       = '0;
                    w_bus_idle_nxt  = 1'b1;
                end
            end
            ST_OWN: begin
                // A transfer that completes in the release cycle is still counted
                w_burst_cnt_nxt = xfer_done ? w_burst_inc : r_burst_cnt;
                if (w_release) begin
                    w_state_nxt    = ST_TURN;
                    w_gnt_nxt      = '0;
                    w_bus_idle_nxt = 1'b1;
                    // The fixed-priority master does not move the rotation
                    w_rr_nxt       = (r_gnt_id != 3'd0) ? r_gnt_id : r_rr;
                end else begin
                    w_state_nxt    = ST_OWN;
                    w_bus_idle_nxt = 1'b0;
                end
            end
            ST_TURN: begin
                w_state_nxt    = ST_IDLE;
                w_gnt_nxt      = '0;
                w_bus_idle_nxt = 1'b1;
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_gnt_nxt      = '0;
                w_bus_idle_nxt = 1'b1;
            end
        endcase
    end

    // State and output registers; reset drops the grant without waiting for a clock
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_gnt_id    <= 3'd0;
            r_bus_idle  <= 1'b1;
            r_burst_cnt <= 8'd0;
            r_rr        <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_bus_idle  <= w_bus_idle_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_rr        <= w_rr_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign bus_idle  = r_bus_idle;
    assign burst_cnt = r_burst_cnt;

endmodule

// File: tb/tb_gpu_bus_arb.sv
// Testbench for gpu_bus_arb (NREQ=4, HOG_IDX=1, MAX_BURST=8).
// Each task pushes the owner it expects onto exp_q before driving the stimulus
// that should produce that grant. A negedge monitor pops and compares on every
// rising grant. The tasks themselves check levels, counts and idle timing inline.
module tb_gpu_bus_arb;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       xfer_done;
    logic       bus_hog;
    logic [3:0] gnt;
    logic [2:0] gnt_id;
    logic       bus_idle;
    logic [7:0] burst_cnt;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_q[$];
    logic [3:0] prev_gnt;
    logic [2:0] mon_e;
    logic [3:0] mon_oh;

    gpu_bus_arb #(.NREQ(4), .HOG_IDX(1), .MAX_BURST(8)) dut (
        .sys_clk   (clk),
        .reset     (rst),
        .req       (req),
        .xfer_done (xfer_done),
        .bus_hog   (bus_hog),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .bus_idle  (bus_idle),
        .burst_cnt (burst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Grant-order monitor: pops the expected owner on each new grant
    always @(negedge clk) begin
        if (rst) begin
            prev_gnt <= 4'b0000;
        end else begin
            if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL grant_order: unexpected grant gnt=%b gnt_id=%0d", gnt, gnt_id);
                end else begin
                    mon_e  = exp_q.pop_front();
                    mon_oh = 4'b0001 << mon_e;
                    if (gnt !== mon_oh || gnt_id !== mon_e) begin
                        errors++;
                        $display("FAIL grant_order: gnt=%b gnt_id=%0d expected gnt=%b gnt_id=%0d",
                                 gnt, gnt_id, mon_oh, mon_e);
                    end
                end
            end
            prev_gnt <= gnt;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int n);
        for (int k = 0; k < n; k++) begin
            xfer_done = 1'b1;
            step(1);
        end
        xfer_done = 1'b0;
    endtask

    task automatic do_reset();
        req = 4'b0000; xfer_done = 1'b0; bus_hog = 1'b0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b0000; xfer_done = 1'b0; bus_hog = 1'b0;
        step(2);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        checks++; if (gnt_id !== 3'd0) begin errors++; $display("FAIL reset_gnt_id: got %0d want 0", gnt_id); end
        checks++; if (burst_cnt !== 8'd0) begin errors++; $display("FAIL reset_burst: got %0d want 0", burst_cnt); end
        checks++; if (bus_idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", bus_idle); end
        rst = 1'b0;
        step(2);
        checks++; if (gnt !== 4'b0000 || bus_idle !== 1'b1) begin
            errors++; $display("FAIL idle_no_req: gnt=%b idle=%b want 0000/1", gnt, bus_idle);
        end
    endtask

    task automatic test_single();
        exp_q.push_back(3'd2);
        req = 4'b0100;
        step(1);
        checks++; if (gnt !== 4'b0100 || gnt_id !== 3'd2) begin
            errors++; $display("FAIL single_latency: gnt=%b id=%0d want 0100/2", gnt, gnt_id);
        end
        checks++; if (bus_idle !== 1'b0 || burst_cnt !== 8'd0) begin
            errors++; $display("FAIL single_start: idle=%b burst=%0d want 0/0", bus_idle, burst_cnt);
        end
        xfer(20);
        checks++; if (gnt !== 4'b0100 || burst_cnt !== 8'd20) begin
            errors++; $display("FAIL single_hold: gnt=%b burst=%0d want 0100/20", gnt, burst_cnt);
        end
        req = 4'b0000;
        step(1);
        checks++; if (gnt !== 4'b0000 || bus_idle !== 1'b1) begin
            errors++; $display("FAIL single_release: gnt=%b idle=%b want 0000/1", gnt, bus_idle);
        end
        step(1);
        checks++; if (bus_idle !== 1'b1 || gnt_id !== 3'd2) begin
            errors++; $display("FAIL single_idle2: idle=%b id=%0d want 1/2", bus_idle, gnt_id);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] ids [4];
        logic [3:0] oh;
        ids[0] = 3'd1; ids[1] = 3'd2; ids[2] = 3'd3; ids[3] = 3'd1;
        do_reset();
        for (int k = 0; k < 4; k++) exp_q.push_back(ids[k]);
        req = 4'b1110;
        step(1);
        for (int o = 0; o < 3; o++) begin
            oh = 4'b0001 << ids[o];
            xfer(7);
            checks++; if (gnt !== oh || burst_cnt !== 8'd7) begin
                errors++; $display("FAIL rr_hold%0d: gnt=%b burst=%0d want %b/7", o, gnt, burst_cnt, oh);
            end
            xfer(1);
            checks++; if (gnt !== 4'b0000 || burst_cnt !== 8'd8) begin
                errors++; $display("FAIL rr_release%0d: gnt=%b burst=%0d want 0000/8", o, gnt, burst_cnt);
            end
            step(1);
            checks++; if (gnt !== 4'b0000) begin
                errors++; $display("FAIL rr_gap%0d: gnt=%b want 0000", o, gnt);
            end
            step(1);
            oh = 4'b0001 << ids[o+1];
            checks++; if (gnt !== oh || gnt_id !== ids[o+1]) begin
                errors++; $display("FAIL rr_next%0d: gnt=%b id=%0d want %b/%0d", o, gnt, gnt_id, oh, ids[o+1]);
            end
        end
        req = 4'b0000;
        step(3);
    endtask

    task automatic test_hog();
        do_reset();
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd3);
        bus_hog = 1'b1;
        req = 4'b1010;
        step(1);
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL hog_win: gnt=%b want 0010", gnt); end
        xfer(30);
        checks++; if (gnt !== 4'b0010 || burst_cnt !== 8'd30) begin
            errors++; $display("FAIL hog_hold: gnt=%b burst=%0d want 0010/30", gnt, burst_cnt);
        end
        bus_hog = 1'b0;
        xfer(1);
        checks++; if (gnt !== 4'b0000 || burst_cnt !== 8'd31) begin
            errors++; $display("FAIL hog_clear_release: gnt=%b burst=%0d want 0000/31", gnt, burst_cnt);
        end
        step(2);
        checks++; if (gnt !== 4'b1000 || gnt_id !== 3'd3) begin
            errors++; $display("FAIL hog_next: gnt=%b id=%0d want 1000/3", gnt, gnt_id);
        end
        req = 4'b0000;
        step(3);
    endtask

    task automatic test_priority_preempt();
        do_reset();
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd2);
        bus_hog = 1'b1;
        req = 4'b0010;
        step(1);
        xfer(10);
        checks++; if (gnt !== 4'b0010 || burst_cnt !== 8'd10) begin
            errors++; $display("FAIL prio_hog_hold: gnt=%b burst=%0d want 0010/10", gnt, burst_cnt);
        end
        req = 4'b0011;
        step(1);
        checks++; if (gnt !== 4'b0010) begin
            errors++; $display("FAIL prio_no_preempt: gnt=%b want 0010", gnt);
        end
        xfer(1);
        checks++; if (gnt !== 4'b0000 || burst_cnt !== 8'd11) begin
            errors++; $display("FAIL prio_release: gnt=%b burst=%0d want 0000/11", gnt, burst_cnt);
        end
        step(2);
        checks++; if (gnt !== 4'b0001 || gnt_id !== 3'd0) begin
            errors++; $display("FAIL prio_grant0: gnt=%b id=%0d want 0001/0", gnt, gnt_id);
        end
        // rr should still be 1, so the next round-robin winner is 2
        bus_hog = 1'b0;
        req = 4'b1110;
        step(3);
        checks++; if (gnt !== 4'b0100 || gnt_id !== 3'd2) begin
            errors++; $display("FAIL prio_rr_kept: gnt=%b id=%0d want 0100/2", gnt, gnt_id);
        end
        req = 4'b0000;
        step(3);
    endtask

    task automatic test_simultaneous();
        do_reset();
        exp_q.push_back(3'd2);
        req = 4'b0100;
        step(1);
        xfer(3);
        xfer_done = 1'b1;
        req = 4'b0000;
        step(1);
        checks++; if (gnt !== 4'b0000 || burst_cnt !== 8'd4 || bus_idle !== 1'b1) begin
            errors++; $display("FAIL simul_release: gnt=%b burst=%0d idle=%b want 0000/4/1", gnt, burst_cnt, bus_idle);
        end
        // still high during TURN, then during IDLE
        step(1);
        checks++; if (burst_cnt !== 8'd4) begin
            errors++; $display("FAIL simul_turn_xfer: burst=%0d want 4", burst_cnt);
        end
        step(1);
        xfer_done = 1'b0;
        checks++; if (burst_cnt !== 8'd4) begin
            errors++; $display("FAIL simul_idle_xfer: burst=%0d want 4", burst_cnt);
        end
        step(2);
        checks++; if (gnt !== 4'b0000 || bus_idle !== 1'b1) begin
            errors++; $display("FAIL simul_single_release: gnt=%b idle=%b want 0000/1", gnt, bus_idle);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        exp_q.push_back(3'd2);
        req = 4'b0100;
        step(1);
        xfer(5);
        checks++; if (gnt !== 4'b0100 || burst_cnt !== 8'd5) begin
            errors++; $display("FAIL rmid_pre: gnt=%b burst=%0d want 0100/5", gnt, burst_cnt);
        end
        rst = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0000 || burst_cnt !== 8'd0 || bus_idle !== 1'b1) begin
            errors++; $display("FAIL rmid_async: gnt=%b burst=%0d idle=%b want 0000/0/1", gnt, burst_cnt, bus_idle);
        end
        #1;
        rst = 1'b0;
        exp_q.push_back(3'd2);
        step(1);
        checks++; if (gnt !== 4'b0100 || gnt_id !== 3'd2) begin
            errors++; $display("FAIL rmid_regrant: gnt=%b id=%0d want 0100/2", gnt, gnt_id);
        end
        req = 4'b0000;
        step(3);
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; xfer_done = 1'b0; bus_hog = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_hog();
        test_priority_preempt();
        test_simultaneous();
        test_reset_mid();
        step(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL grant_queue_drain: %0d expected grants never seen, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
